// File: rtl/pe_seq_ctrl.sv
// pe_seq_ctrl: streams neuron/weight chunks from two 1-cycle SRAMs into one parallel_pe and stores each partial sum.
// Latency: first read 1 cycle after start; done pulses N*L+3 cycles after start (1 cycle after start for zero config).
// Backpressure: none; one read per cycle while running, and each PE result is written in the cycle it arrives.
// Optional: define PE_SEQ_PERF_CNT_EN to add the perf_cycles busy-cycle counter output.
module pe_seq_ctrl #(
  parameter int ADDR_W = 8,
  parameter int LEN_W  = 8,
  parameter int OUT_W  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [LEN_W-1:0]  cfg_vec_len,
  input  logic [OUT_W-1:0]  cfg_out_num,
  output logic              busy,
  output logic              done,
  output logic              nram_rd_en,
  output logic [ADDR_W-1:0] nram_addr,
  output logic              wram_rd_en,
  output logic [ADDR_W-1:0] wram_addr,
  output logic [1:0]        pe_ctl,
  output logic              pe_vld_i,
  input  logic              pe_vld_o,
  input  logic [31:0]       pe_result,
  output logic              out_wr_en,
  output logic [ADDR_W-1:0] out_addr,
  output logic [31:0]       out_data
`ifdef PE_SEQ_PERF_CNT_EN
  ,
  output logic [31:0]       perf_cycles
`endif
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  state_t            state;
  logic [LEN_W-1:0]  l_q;     // chunks per output, frozen for the job
  logic [OUT_W-1:0]  n_q;     // outputs per job, frozen for the job
  logic [LEN_W-1:0]  k_cnt;   // chunk index within the current output being read
  logic [OUT_W-1:0]  o_rd;    // output index currently being read
  logic [OUT_W-1:0]  o_wr;    // output index of the next result to be written
  logic              rd_en;
  logic              wr_fire;

  // PE results are only trusted while a job is in flight; a reset or idle PE cannot write
  assign wr_fire    = pe_vld_o & busy;
  assign out_wr_en  = wr_fire;
  assign out_data   = wr_fire ? pe_result : 32'h0;
  assign out_addr   = ADDR_W'(o_wr);
  assign nram_rd_en = rd_en;
  assign wram_rd_en = rd_en;
  assign nram_addr  = ADDR_W'(k_cnt);

  // Job FSM: read issue, PE strobes delayed one cycle to meet SRAM data, write tracking
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      l_q       <= '0;
      n_q       <= '0;
      k_cnt     <= '0;
      o_rd      <= '0;
      o_wr      <= '0;
      rd_en     <= 1'b0;
      wram_addr <= '0;
      pe_vld_i  <= 1'b0;
      pe_ctl    <= 2'b00;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      pe_vld_i <= rd_en;
      pe_ctl   <= rd_en ? {k_cnt == l_q - LEN_W'(1), k_cnt == '0} : 2'b00;
      if (wr_fire) o_wr <= o_wr + OUT_W'(1);

      case (state)
        ST_IDLE: begin
          if (start) begin
            l_q       <= cfg_vec_len;
            n_q       <= cfg_out_num;
            k_cnt     <= '0;
            o_rd      <= '0;
            o_wr      <= '0;
            wram_addr <= '0;
            if (cfg_vec_len == '0 || cfg_out_num == '0) begin
              // Nothing to compute: report completion straight away
              state <= ST_DONE;
              done  <= 1'b1;
            end else begin
              state <= ST_RUN;
              busy  <= 1'b1;
              rd_en <= 1'b1;
            end
          end
        end
        ST_RUN: begin
          wram_addr <= wram_addr + ADDR_W'(1);
          if (k_cnt == l_q - LEN_W'(1)) begin
            k_cnt <= '0;
            o_rd  <= o_rd + OUT_W'(1);
            if (o_rd == n_q - OUT_W'(1)) begin
              // Final chunk issued this cycle; wait for the PE to flush
              rd_en     <= 1'b0;
              wram_addr <= '0;
              o_rd      <= '0;
              state     <= ST_DRAIN;
            end
          end else begin
            k_cnt <= k_cnt + LEN_W'(1);
          end
        end
        ST_DRAIN: begin
          if (wr_fire && o_wr == n_q - OUT_W'(1)) begin
            state <= ST_DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
            o_wr  <= '0;
          end
        end
        ST_DONE: begin
          done  <= 1'b0;
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

`ifdef PE_SEQ_PERF_CNT_EN
  // Busy-cycle counter: cleared on an accepted start, saturating, held after done
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_cycles <= 32'h0;
    end else if (state == ST_IDLE && start) begin
      perf_cycles <= 32'h0;
    end else if (busy && perf_cycles != 32'hFFFF_FFFF) begin
      perf_cycles <= perf_cycles + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_pe_seq_ctrl.sv
// Testbench for pe_seq_ctrl: SRAM and PE behavioural models around the sequencer,
// directed jobs with per-cycle expected strobes, addresses and written results.
module tb_pe_seq_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [7:0]  cfg_vec_len;
  logic [7:0]  cfg_out_num;
  logic        busy, done;
  logic        nram_rd_en, wram_rd_en;
  logic [7:0]  nram_addr, wram_addr;
  logic [1:0]  pe_ctl;
  logic        pe_vld_i;
  logic        pe_vld_o;
  logic [31:0] pe_result;
  logic        out_wr_en;
  logic [7:0]  out_addr;
  logic [31:0] out_data;
`ifdef PE_SEQ_PERF_CNT_EN
  logic [31:0] perf_cycles;
`endif

  int n_checks = 0;
  int n_pass   = 0;
  int w_mode   = 0;  // 0: weights all 8'h01, 1: weight byte = wram_addr+1

  pe_seq_ctrl dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .cfg_vec_len (cfg_vec_len),
    .cfg_out_num (cfg_out_num),
    .busy        (busy),
    .done        (done),
    .nram_rd_en  (nram_rd_en),
    .nram_addr   (nram_addr),
    .wram_rd_en  (wram_rd_en),
    .wram_addr   (wram_addr),
    .pe_ctl      (pe_ctl),
    .pe_vld_i    (pe_vld_i),
    .pe_vld_o    (pe_vld_o),
    .pe_result   (pe_result),
    .out_wr_en   (out_wr_en),
    .out_addr    (out_addr),
    .out_data    (out_data)
`ifdef PE_SEQ_PERF_CNT_EN
    ,
    .perf_cycles (perf_cycles)
`endif
  );

  always #5 clk = ~clk;

  // SRAM + PE models: 1-cycle read latency, PE accumulates bytewise products, emits 1 cycle after last chunk
  logic [511:0] n_dat, w_dat;
  logic [31:0]  psum;
  logic [31:0]  acc;
  logic [7:0]   w_byte;

  function automatic logic [31:0] dot(input logic [511:0] a, input logic [511:0] b);
    logic [31:0] s = 32'h0;
    for (int i = 0; i < 64; i++) s = s + 32'(a[8*i +: 8]) * 32'(b[8*i +: 8]);
    return s;
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      pe_vld_o  <= 1'b0;
      pe_result <= 32'h0;
      psum      <= 32'h0;
      n_dat     <= '0;
      w_dat     <= '0;
    end else begin
      w_byte = (w_mode != 0) ? (wram_addr + 8'd1) : 8'h01;
      if (nram_rd_en) n_dat <= {64{8'h01}};
      if (wram_rd_en) w_dat <= {64{w_byte}};
      pe_vld_o <= 1'b0;
      if (pe_vld_i) begin
        acc = (pe_ctl[0] ? 32'h0 : psum) + dot(n_dat, w_dat);
        psum <= acc;
        if (pe_ctl[1]) begin
          pe_vld_o  <= 1'b1;
          pe_result <= acc;
        end
      end
    end
  end

  // Observed strobe vector: {busy, done, nram_rd_en, wram_rd_en, pe_vld_i, pe_ctl, out_wr_en}
  wire [7:0] st = {busy, done, nram_rd_en, wram_rd_en, pe_vld_i, pe_ctl, out_wr_en};

  function automatic logic [7:0] mk(input bit b, input bit d, input bit r, input bit v,
                                    input logic [1:0] c, input bit w);
    return {b, d, r, r, v, c, w};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; cfg_vec_len = 8'd0; cfg_out_num = 8'd0;
    tick(); tick(); tick();
    n_checks++;
    if (st !== 8'h00) $display("FAIL reset_strobes got %b exp %b", st, 8'h00);
    else n_pass++;
    n_checks++;
    if ({nram_addr, wram_addr, out_addr, out_data} !== 56'h0)
      $display("FAIL reset_addr_data got %h exp 0", {nram_addr, wram_addr, out_addr, out_data});
    else n_pass++;
`ifdef PE_SEQ_PERF_CNT_EN
    n_checks++;
    if (perf_cycles !== 32'h0) $display("FAIL reset_perf got %0d exp 0", perf_cycles);
    else n_pass++;
`endif
    rst = 1'b0;
    tick();
  endtask

  task automatic test_basic();
    logic [7:0] e;
    int k;
    w_mode = 1; cfg_vec_len = 8'd3; cfg_out_num = 8'd2; start = 1'b1;
    for (int t = 1; t <= 11; t++) begin
      tick(); start = 1'b0;
      k = (t - 2) % 3;
      e = mk(t <= 8, t == 9, t <= 6, t >= 2 && t <= 7,
             (t >= 2 && t <= 7) ? {k == 2, k == 0} : 2'b00, t == 5 || t == 8);
      n_checks++;
      if (st !== e) $display("FAIL basic_strobes t=%0d got %b exp %b", t, st, e);
      else n_pass++;
      if (t <= 6) begin
        n_checks++;
        if (nram_addr !== 8'((t - 1) % 3) || wram_addr !== 8'(t - 1))
          $display("FAIL basic_addr t=%0d got n=%0d w=%0d exp n=%0d w=%0d",
                   t, nram_addr, wram_addr, (t - 1) % 3, t - 1);
        else n_pass++;
      end
      if (t == 5 || t == 8) begin
        n_checks++;
        if (out_addr !== ((t == 5) ? 8'd0 : 8'd1) || out_data !== ((t == 5) ? 32'd384 : 32'd960))
          $display("FAIL basic_write t=%0d got a=%0d d=%0d exp a=%0d d=%0d",
                   t, out_addr, out_data, (t == 5) ? 0 : 1, (t == 5) ? 384 : 960);
        else n_pass++;
      end
    end
  endtask

  task automatic test_single_chunk();
    logic [7:0] e;
    w_mode = 0; cfg_vec_len = 8'd1; cfg_out_num = 8'd3; start = 1'b1;
    for (int t = 1; t <= 8; t++) begin
      tick(); start = 1'b0;
      e = mk(t <= 5, t == 6, t <= 3, t >= 2 && t <= 4,
             (t >= 2 && t <= 4) ? 2'b11 : 2'b00, t >= 3 && t <= 5);
      n_checks++;
      if (st !== e) $display("FAIL single_strobes t=%0d got %b exp %b", t, st, e);
      else n_pass++;
      if (t >= 3 && t <= 5) begin
        n_checks++;
        if (out_addr !== 8'(t - 3) || out_data !== 32'd64)
          $display("FAIL single_write t=%0d got a=%0d d=%0d exp a=%0d d=64", t, out_addr, out_data, t - 3);
        else n_pass++;
      end
    end
  endtask

  task automatic test_zero_cfg();
    logic [7:0] e;
    for (int c = 0; c < 2; c++) begin
      cfg_vec_len = (c == 0) ? 8'd0 : 8'd3;
      cfg_out_num = (c == 0) ? 8'd5 : 8'd0;
      start = 1'b1;
      for (int t = 1; t <= 3; t++) begin
        tick(); start = 1'b0;
        e = mk(1'b0, t == 1, 1'b0, 1'b0, 2'b00, 1'b0);
        n_checks++;
        if (st !== e) $display("FAIL zero_cfg c=%0d t=%0d got %b exp %b", c, t, st, e);
        else n_pass++;
      end
    end
  endtask

  task automatic test_start_busy();
    logic [7:0] e;
    int u, k;
    w_mode = 0; cfg_vec_len = 8'd2; cfg_out_num = 8'd2; start = 1'b1;
    for (int t = 1; t <= 13; t++) begin
      tick(); start = 1'b0;
      u = t - 8;
      k = (t - 2) % 2;
      e = mk((t <= 6) || (u >= 1 && u <= 3), t == 7 || u == 4, t <= 4 || u == 1,
             (t >= 2 && t <= 5) || u == 2,
             (t >= 2 && t <= 5) ? {k == 1, k == 0} : ((u == 2) ? 2'b11 : 2'b00),
             t == 4 || t == 6 || u == 3);
      n_checks++;
      if (st !== e) $display("FAIL start_busy t=%0d got %b exp %b", t, st, e);
      else n_pass++;
      if (t == 4 || t == 6 || u == 3) begin
        n_checks++;
        if (out_data !== ((t < 8) ? 32'd128 : 32'd64))
          $display("FAIL start_busy_data t=%0d got %0d exp %0d", t, out_data, (t < 8) ? 128 : 64);
        else n_pass++;
      end
      if (t == 3) begin
        start = 1'b1; cfg_vec_len = 8'd5; cfg_out_num = 8'd5;
      end
      if (t == 8) begin
        start = 1'b1; cfg_vec_len = 8'd1; cfg_out_num = 8'd1;
      end
    end
  endtask

  task automatic test_reset_mid_job();
    logic [7:0] e;
    int k;
    w_mode = 0; cfg_vec_len = 8'd4; cfg_out_num = 8'd4; start = 1'b1;
    for (int t = 1; t <= 16; t++) begin
      tick(); start = 1'b0; rst = 1'b0;
      k = (t - 2) % 4;
      if (t <= 6) e = mk(1'b1, 1'b0, 1'b1, t >= 2, (t >= 2) ? {k == 3, k == 0} : 2'b00, t == 6);
      else        e = 8'h00;
      n_checks++;
      if (st !== e) $display("FAIL rst_mid t=%0d got %b exp %b", t, st, e);
      else n_pass++;
      if (t == 7) begin
        n_checks++;
        if ({nram_addr, wram_addr, out_addr, out_data} !== 56'h0)
          $display("FAIL rst_mid_zero got %h exp 0", {nram_addr, wram_addr, out_addr, out_data});
        else n_pass++;
      end
      if (t == 6) rst = 1'b1;
    end
    cfg_vec_len = 8'd2; cfg_out_num = 8'd1; start = 1'b1;
    for (int t = 1; t <= 6; t++) begin
      tick(); start = 1'b0;
      e = mk(t <= 4, t == 5, t <= 2, t == 2 || t == 3,
             (t == 2) ? 2'b01 : ((t == 3) ? 2'b10 : 2'b00), t == 4);
      n_checks++;
      if (st !== e) $display("FAIL rst_fresh t=%0d got %b exp %b", t, st, e);
      else n_pass++;
      if (t == 4) begin
        n_checks++;
        if (out_addr !== 8'd0 || out_data !== 32'd128)
          $display("FAIL rst_fresh_write got a=%0d d=%0d exp a=0 d=128", out_addr, out_data);
        else n_pass++;
      end
    end
  endtask

`ifdef PE_SEQ_PERF_CNT_EN
  task automatic test_perf();
    w_mode = 0; cfg_vec_len = 8'd3; cfg_out_num = 8'd2; start = 1'b1;
    for (int t = 1; t <= 16; t++) begin
      tick(); start = 1'b0;
      if (t == 4 || t == 9 || t == 12 || t == 13 || t == 16) begin
        n_checks++;
        if (perf_cycles !== ((t == 4) ? 32'd3 : (t == 13) ? 32'd0 : (t == 16) ? 32'd3 : 32'd8))
          $display("FAIL perf t=%0d got %0d", t, perf_cycles);
        else n_pass++;
      end
      if (t == 12) begin
        start = 1'b1; cfg_vec_len = 8'd1; cfg_out_num = 8'd1;
      end
    end
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_single_chunk();
    test_zero_cfg();
    test_start_busy();
    test_reset_mid_job();
`ifdef PE_SEQ_PERF_CNT_EN
    test_perf();
`endif
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
